vga_img_buffer: RTL
===================

Name: vga_img_buffer

Overview:
- Frame store and pixel fetch stage between the UART image receiver and the VGA output pins.
- Write side: accepts a byte stream from the UART receiver, frames it with a start-of-frame byte, and loads an IMG_W x IMG_H image into dual-port block RAM.
- Read side: consumes h_count, v_count, display_en, h_sync and v_sync from vga_sync. Upscales the image by 2^SCALE_SHIFT and drives rgb plus sync outputs re-aligned to the memory latency.

Parameters:
- IMG_W, 160, stored image width in pixels
- IMG_H, 120, stored image height in pixels
- SCALE_SHIFT, 2, upscale factor log2 (160x120 -> 640x480)
- PIX_W, 3, bits per pixel (R,G,B one bit each; taken from rx_data[PIX_W-1:0])
- SOF_BYTE, 8'hA5, start-of-frame marker

Ports:
- clk_in  in  1  pixel clock (clk_sys from vga_sync); the only clock
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  buffer accepts byte this cycle
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
- h_count  in  10  horizontal pixel position
- v_count  in  10  vertical pixel position
- display_en  in  1  active video
- h_sync_in  in  1  horizontal sync, active-low
- v_sync_in  in  1  vertical sync, active-low
- rgb  out  PIX_W  pixel colour, bit2=R, bit1=G, bit0=B
- h_sync  out  1  delayed h_sync_in
- v_sync  out  1  delayed v_sync_in

Behaviour:
- Clock and reset: one clock, clk_in; reset_n is asynchronous and active-low.
- Reset values: rx_ready=0, frame_done=0, rgb=0, h_sync=1, v_sync=1, write address 0, FSM=IDLE. RAM contents are not cleared.
- Byte transfer rule: a byte transfers on a cycle with rx_valid && rx_ready.
- Write FSM states:
  - IDLE: rx_ready=1. A transferred byte equal to SOF_BYTE -> LOAD with wr_addr=0. Any other byte is dropped; stay in IDLE.
  - LOAD: rx_ready=1. Each transferred byte writes rx_data[PIX_W-1:0] to RAM[wr_addr], then wr_addr++. On the write to wr_addr == IMG_W*IMG_H-1 -> DONE. SOF_BYTE in LOAD is pixel data, not a resync.
  - DONE: rx_ready=0 for exactly one cycle, frame_done=1 that cycle, then -> IDLE.
- wr_addr width: clog2(IMG_W*IMG_H), i.e. 15 bits at the defaults.
- Reset mid-LOAD aborts the frame. RAM keeps the partial image; the next frame requires a fresh SOF_BYTE.
- Read pipeline, total latency 2 clk_in cycles:
  - Stage 1 (registered): px = h_count>>SCALE_SHIFT, py = v_count>>SCALE_SHIFT, rd_addr = py*IMG_W + px. Also register in_img = display_en && px<IMG_W && py<IMG_H, plus both syncs.
  - Stage 2: registered RAM read. rgb = in_img_d ? RAM data : 0. h_sync/v_sync delayed by the same 2 cycles.
- Reads and writes to the same address in the same cycle: the read returns old data. Tearing during a load is acceptable.
- The address multiply is constant (IMG_W). The rd_addr width equals the wr_addr width; no wrap.

Optional Feature:
- Macro: VGA_IMG_TEST_PATTERN_EN.
- When defined:
  - Adds input port test_mode (1 bit).
  - When test_mode=1, stage 2 outputs rgb = h_count_d[8:6] (eight 64-pixel vertical colour bars) instead of RAM data, still gated by in_img_d.
  - The write side is unaffected.
- When undefined: no test_mode port; rgb always comes from RAM.

Decomposition:
- Package vga_img_pkg: IMG_W, IMG_H, SCALE_SHIFT, PIX_W, SOF_BYTE, derived FB_DEPTH/FB_AW, and the write-FSM state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2).
- Sub-module img_bram: simple dual-port RAM, one write port and one registered read port, same clock, inferable as iCE40 BRAM.

Test Plan:
- Reset: hold reset_n=0 mid-line -> rgb=0, h_sync=1, v_sync=1, rx_ready=0; after release, rx_ready=1 next cycle.
- Framing: send 0x11, 0x22 (dropped), then 0xA5 followed by 19200 bytes with value i%8 -> frame_done pulses once, 1 cycle after the last write, and rx_ready=0 that cycle. Reading back at h=4, v=0 gives rgb=1.
- Scaling and latency: image pixel (px=1, py=2)=3'b101; drive h_count=4..7, v_count=8 with display_en=1 -> rgb=3'b101 exactly 2 cycles after each input; h_sync/v_sync edges also delayed by 2.
- Blanking: display_en=0 at h=700, or when the address falls outside the image -> rgb=0 while syncs still propagate.
- Abort: assert reset_n low after 100 LOAD bytes, release, send 50 bytes without SOF -> no RAM writes, no frame_done.
- With VGA_IMG_TEST_PATTERN_EN and test_mode=1: h_count=130, display_en=1 -> rgb=3'b010 two cycles later.

Source files
------------

// File: rtl/vga_img_pkg.sv
// Shared constants, types and write-FSM encoding for the VGA frame store.
// Pure declarations: no latency or flow control of its own.
package vga_img_pkg;

  localparam int IMG_W       = 160;
  localparam int IMG_H       = 120;
  localparam int SCALE_SHIFT = 2;
  localparam int PIX_W       = 3;
  localparam logic [7:0] SOF_BYTE = 8'hA5;

  localparam int FB_DEPTH = IMG_W * IMG_H;
  localparam int FB_AW    = $clog2(FB_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic [FB_AW-1:0] fb_addr_t;
  typedef logic [PIX_W-1:0] pix_t;

  // Row-major frame buffer address; out-of-image coordinates are gated elsewhere.
  function automatic fb_addr_t pix_addr(input logic [9:0] px, input logic [9:0] py);
    return fb_addr_t'(py) * fb_addr_t'(IMG_W) + fb_addr_t'(px);
  endfunction

endpackage

// File: rtl/img_bram.sv
// Simple dual-port RAM, one write port and one registered read port on one clock.
// Read latency 1 cycle, same-address read returns old data; no backpressure.
module img_bram #(
  parameter int AW    = 15,
  parameter int DW    = 3,
  parameter int DEPTH = 19200
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_img_buffer.sv
// Frame store: SOF-framed UART bytes into BRAM; scaled pixel fetch, rgb/syncs 2 cycles after h/v_count.
// rx_ready drops for the single DONE cycle only; optional test bars via VGA_IMG_TEST_PATTERN_EN.
module vga_img_buffer
  import vga_img_pkg::*;
(
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             frame_done,
  input  logic [9:0]       h_count,
  input  logic [9:0]       v_count,
  input  logic             display_en,
  input  logic             h_sync_in,
  input  logic             v_sync_in,
  output logic [PIX_W-1:0] rgb,
  output logic             h_sync,
  output logic             v_sync
`ifdef VGA_IMG_TEST_PATTERN_EN
  ,
  input  logic             test_mode
`endif
);

  // ---------------- write side ----------------
  logic [1:0] state, state_nxt;
  fb_addr_t   wr_addr;
  logic       xfer, wr_en, last_px;

  assign xfer    = rx_valid && rx_ready;
  assign wr_en   = xfer && (state == ST_LOAD);
  assign last_px = (wr_addr == fb_addr_t'(FB_DEPTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (xfer && (rx_data == SOF_BYTE)) state_nxt = ST_LOAD;
      ST_LOAD: if (wr_en && last_px) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // rx_ready is registered so it stays low through reset and the DONE cycle.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      wr_addr  <= '0;
      rx_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      rx_ready <= (state_nxt != ST_DONE);
      if (state == ST_IDLE) begin
        wr_addr <= '0;
      end else if (wr_en) begin
        wr_addr <= wr_addr + fb_addr_t'(1);
      end
    end
  end

  assign frame_done = (state == ST_DONE);

  // ---------------- read side ----------------
  logic [9:0] px, py;
  fb_addr_t   rd_addr;
  logic       in_img, in_img_d;
  logic       hs_1, vs_1, hs_2, vs_2;
  pix_t       ram_q;

  assign px = h_count >> SCALE_SHIFT;
  assign py = v_count >> SCALE_SHIFT;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr  <= '0;
      in_img   <= 1'b0;
      in_img_d <= 1'b0;
      hs_1     <= 1'b1;
      vs_1     <= 1'b1;
      hs_2     <= 1'b1;
      vs_2     <= 1'b1;
    end else begin
      rd_addr  <= pix_addr(px, py);
      in_img   <= display_en && (px < 10'(IMG_W)) && (py < 10'(IMG_H));
      in_img_d <= in_img;
      hs_1     <= h_sync_in;
      vs_1     <= v_sync_in;
      hs_2     <= hs_1;
      vs_2     <= vs_1;
    end
  end

  img_bram #(
    .AW    (FB_AW),
    .DW    (PIX_W),
    .DEPTH (FB_DEPTH)
  ) u_bram (
    .clk     (clk_in),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (rx_data[PIX_W-1:0]),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  assign h_sync = hs_2;
  assign v_sync = vs_2;

`ifdef VGA_IMG_TEST_PATTERN_EN
  // 64-pixel colour bars from the raw h_count, aligned with the RAM read.
  logic [2:0] bar_1, bar_d;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      bar_1 <= '0;
      bar_d <= '0;
    end else begin
      bar_1 <= h_count[8:6];
      bar_d <= bar_1;
    end
  end

  always_comb begin
    rgb = '0;
    if (in_img_d) begin
      rgb = test_mode ? bar_d : ram_q;
    end
  end
`else
  always_comb begin
    rgb = '0;
    if (in_img_d) begin
      rgb = ram_q;
    end
  end
`endif

endmodule
